rf_write_port_arbiter: RTL and testbench

//  Shares the single register-file write port between three writers:
//  - the pipeline write-back stage (WB);
//  - the long-latency execution unit (LL; multiply/divide results);
//  - the debug/loader port (DBG).

---
 rtl/rf_arb_pkg.sv | 21 ++
 rtl/rf_write_port_arbiter_rr2.sv | 47 ++++
 rtl/rf_write_port_arbiter.sv | 113 +++++++++++
 tb/tb_rf_write_port_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter: address width,
// the r0 constant, requester ids for the grant mux, and the round-robin pointer.
package rf_arb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_WB   = 2'd1,
    REQ_LL   = 2'd2,
    REQ_DBG  = 2'd3
  } req_id_e;

  // Which secondary requester wins a tie: FIRST = req[0] (LL), SECOND = req[1] (DBG).
  typedef enum logic {
    RR_FIRST  = 1'b0,
    RR_SECOND = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/rf_write_port_arbiter_rr2.sv
// Two-way round-robin arbiter. The pointer names the tie winner; after any
// grant it is set to the requester that did not win.
module arb_rr2
  import rf_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  rr_ptr_e ptr_q, ptr_d;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    if (en) begin
      case (req)
        2'b01: begin
          gnt   = 2'b01;
          ptr_d = RR_SECOND;
        end
        2'b10: begin
          gnt   = 2'b10;
          ptr_d = RR_FIRST;
        end
        2'b11: begin
          if (ptr_q == RR_FIRST) begin
            gnt   = 2'b01;
            ptr_d = RR_SECOND;
          end else begin
            gnt   = 2'b10;
            ptr_d = RR_FIRST;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= RR_FIRST;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_write_port_arbiter.sv
// Arbitrates the single regfile write port between WB, the long-latency unit
// and the debug port, with a one-cycle pipeline stall to prevent starvation.
module rf_write_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned STARVE_LIMIT     = 4,
  parameter int unsigned ZERO_REG_PROTECT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wb_we,
  input  logic [REG_ADDR_W-1:0] i_wb_rdst,
  input  logic [WIDTH-1:0]      i_wb_data,
  input  logic                  i_ll_valid,
  input  logic [REG_ADDR_W-1:0] i_ll_rdst,
  input  logic [WIDTH-1:0]      i_ll_data,
  output logic                  o_ll_ready,
  input  logic                  i_dbg_valid,
  input  logic [REG_ADDR_W-1:0] i_dbg_rdst,
  input  logic [WIDTH-1:0]      i_dbg_data,
  output logic                  o_dbg_ready,
  output logic                  o_stall_pipe,
  output logic                  o_rf_we,
  output logic [REG_ADDR_W-1:0] o_rf_rdst,
  output logic [WIDTH-1:0]      o_rf_data
);

  localparam int unsigned      CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic             PROTECT = (ZERO_REG_PROTECT != 0);

  logic                  wb_req;
  logic [1:0]            sec_gnt;
  req_id_e               gnt_id;
  logic [REG_ADDR_W-1:0] gnt_rdst;
  logic [WIDTH-1:0]      gnt_data;

  logic                  stall_q, stall_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_rdst_q;
  logic [WIDTH-1:0]      rf_data_q;

  // A WB write to r0 is dropped up front so it never blocks LL/DBG.
  assign wb_req = i_wb_we & ~stall_q & ~(PROTECT & (i_wb_rdst == ZERO_REG));

  // Gating en with rst keeps ready low and the pointer parked during reset.
  arb_rr2 u_rr (
    .clk (clk),
    .rst (rst),
    .req ({i_dbg_valid, i_ll_valid}),
    .en  (~wb_req & ~rst),
    .gnt (sec_gnt)
  );

  assign o_ll_ready  = sec_gnt[0];
  assign o_dbg_ready = sec_gnt[1];

  always_comb begin
    gnt_id   = REQ_NONE;
    gnt_rdst = '0;
    gnt_data = '0;
    if (wb_req && !rst) begin
      gnt_id   = REQ_WB;
      gnt_rdst = i_wb_rdst;
      gnt_data = i_wb_data;
    end else if (sec_gnt[0]) begin
      gnt_id   = REQ_LL;
      gnt_rdst = i_ll_rdst;
      gnt_data = i_ll_data;
    end else if (sec_gnt[1]) begin
      gnt_id   = REQ_DBG;
      gnt_rdst = i_dbg_rdst;
      gnt_data = i_dbg_data;
    end
    rf_we_d = (gnt_id != REQ_NONE) && !(PROTECT && (gnt_rdst == ZERO_REG));
  end

  // Counts cycles a secondary requester waits; stall fires when it hits the limit.
  always_comb begin
    cnt_d   = cnt_q;
    stall_d = 1'b0;
    if ((|sec_gnt) || !(i_ll_valid || i_dbg_valid)) begin
      cnt_d = '0;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      stall_d = (cnt_d == CNT_MAX) && !stall_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q   <= 1'b0;
      cnt_q     <= '0;
      rf_we_q   <= 1'b0;
      rf_rdst_q <= '0;
      rf_data_q <= '0;
    end else begin
      stall_q   <= stall_d;
      cnt_q     <= cnt_d;
      rf_we_q   <= rf_we_d;
      rf_rdst_q <= gnt_rdst;
      rf_data_q <= gnt_data;
    end
  end

  assign o_stall_pipe = stall_q;
  assign o_rf_we      = rf_we_q;
  assign o_rf_rdst    = rf_rdst_q;
  assign o_rf_data    = rf_data_q;

endmodule

// File: tb/tb_rf_write_port_arbiter.sv
// Self-checking bench for rf_write_port_arbiter: directed scenarios followed by
// randomized traffic compared against a cycle-level behavioural model.
module tb_rf_write_port_arbiter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned LIMIT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_wb_we, i_ll_valid, i_dbg_valid;
  logic [4:0]       i_wb_rdst, i_ll_rdst, i_dbg_rdst;
  logic [WIDTH-1:0] i_wb_data, i_ll_data, i_dbg_data;
  logic             o_ll_ready, o_dbg_ready, o_stall_pipe, o_rf_we;
  logic [4:0]       o_rf_rdst;
  logic [WIDTH-1:0] o_rf_data;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: what the regfile should see next, who wins a tie,
  // how long a secondary requester has waited, and whether the pipe is stalled.
  bit               m_we;
  bit [4:0]         m_rdst;
  bit [WIDTH-1:0]   m_data;
  bit               m_stall;
  int               m_fav;   // 0: LL wins a tie, 1: DBG wins a tie
  int               m_wait;

  rf_write_port_arbiter #(
    .WIDTH            (WIDTH),
    .STARVE_LIMIT     (LIMIT),
    .ZERO_REG_PROTECT (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_wb_we      (i_wb_we),
    .i_wb_rdst    (i_wb_rdst),
    .i_wb_data    (i_wb_data),
    .i_ll_valid   (i_ll_valid),
    .i_ll_rdst    (i_ll_rdst),
    .i_ll_data    (i_ll_data),
    .o_ll_ready   (o_ll_ready),
    .i_dbg_valid  (i_dbg_valid),
    .i_dbg_rdst   (i_dbg_rdst),
    .i_dbg_data   (i_dbg_data),
    .o_dbg_ready  (o_dbg_ready),
    .o_stall_pipe (o_stall_pipe),
    .o_rf_we      (o_rf_we),
    .o_rf_rdst    (o_rf_rdst),
    .o_rf_data    (o_rf_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    i_wb_we = 1'b0;  i_wb_rdst = '0;  i_wb_data = '0;
    i_ll_valid = 1'b0;  i_ll_rdst = '0;  i_ll_data = '0;
    i_dbg_valid = 1'b0; i_dbg_rdst = '0; i_dbg_data = '0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // 0 = nobody, 1 = WB, 2 = LL, 3 = DBG
  function automatic int model_pick();
    if (rst) return 0;
    if (i_wb_we && !m_stall && i_wb_rdst != 0) return 1;
    if (i_ll_valid && i_dbg_valid) return (m_fav == 0) ? 2 : 3;
    if (i_ll_valid) return 2;
    if (i_dbg_valid) return 3;
    return 0;
  endfunction

  task automatic model_step(input int g);
    bit [4:0]       rd;
    bit [WIDTH-1:0] dat;
    bit             nstall;
    if (rst) begin
      m_we = 0; m_rdst = 0; m_data = 0; m_stall = 0; m_fav = 0; m_wait = 0;
      return;
    end
    rd = 0; dat = 0; nstall = 0;
    if (g == 1) begin rd = i_wb_rdst;  dat = i_wb_data;  end
    if (g == 2) begin rd = i_ll_rdst;  dat = i_ll_data;  m_fav = 1; end
    if (g == 3) begin rd = i_dbg_rdst; dat = i_dbg_data; m_fav = 0; end
    if (g >= 2 || !(i_ll_valid || i_dbg_valid)) begin
      m_wait = 0;
    end else begin
      if (m_wait < LIMIT) m_wait++;
      nstall = (m_wait == LIMIT) && !m_stall;
    end
    m_stall = nstall;
    m_we    = (g != 0) && (rd != 0);
    m_rdst  = rd;
    m_data  = dat;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_wb_we = 1'b1;  i_wb_rdst = 5'd3; i_wb_data = 32'h1;
    i_ll_valid = 1'b1; i_ll_rdst = 5'd7; i_dbg_valid = 1'b1; i_dbg_rdst = 5'd5;
    for (int unsigned k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({o_ll_ready, o_dbg_ready, o_stall_pipe} !== 3'b000) begin
        errors++; $display("FAIL reset_ctrl: got %b want 000", {o_ll_ready, o_dbg_ready, o_stall_pipe});
      end
      checks++;
      if ({o_rf_we, o_rf_rdst, o_rf_data} !== 38'd0) begin
        errors++; $display("FAIL reset_rf: got %h want 0", {o_rf_we, o_rf_rdst, o_rf_data});
      end
    end
    rst = 1'b0;
    set_idle();
    tick();
  endtask

  task automatic test_single_ll();
    i_ll_valid = 1'b1; i_ll_rdst = 5'd7; i_ll_data = 32'hA5A5A5A5;
    #1;
    checks++;
    if ({o_ll_ready, o_dbg_ready} !== 2'b10) begin
      errors++; $display("FAIL single_ll_ready: got %b want 10", {o_ll_ready, o_dbg_ready});
    end
    tick();
    i_ll_valid = 1'b0;
    checks++;
    if ({o_rf_we, o_rf_rdst, o_rf_data} !== {1'b1, 5'd7, 32'hA5A5A5A5}) begin
      errors++; $display("FAIL single_ll_write: got %h want %h", {o_rf_we, o_rf_rdst, o_rf_data}, {1'b1, 5'd7, 32'hA5A5A5A5});
    end
    tick();
    checks++;
    if (o_rf_we !== 1'b0) begin
      errors++; $display("FAIL single_ll_idle: got we=%b want 0", o_rf_we);
    end
  endtask

  task automatic test_wb_rr();
    do_reset();
    i_wb_we = 1'b1;     i_wb_rdst = 5'd3;  i_wb_data = 32'h33333333;
    i_ll_valid = 1'b1;  i_ll_rdst = 5'd4;  i_ll_data = 32'h44444444;
    i_dbg_valid = 1'b1; i_dbg_rdst = 5'd5; i_dbg_data = 32'h55555555;
    #1;
    checks++;
    if ({o_ll_ready, o_dbg_ready} !== 2'b00) begin
      errors++; $display("FAIL rr_wb_first_ready: got %b want 00", {o_ll_ready, o_dbg_ready});
    end
    tick();
    i_wb_we = 1'b0;
    checks++;
    if ({o_rf_we, o_rf_rdst, o_rf_data} !== {1'b1, 5'd3, 32'h33333333}) begin
      errors++; $display("FAIL rr_write_r3: got %h", {o_rf_we, o_rf_rdst, o_rf_data});
    end
    #1;
    checks++;
    if ({o_ll_ready, o_dbg_ready} !== 2'b10) begin
      errors++; $display("FAIL rr_ll_ready: got %b want 10", {o_ll_ready, o_dbg_ready});
    end
    tick();
    i_ll_valid = 1'b0;
    checks++;
    if ({o_rf_we, o_rf_rdst, o_rf_data} !== {1'b1, 5'd4, 32'h44444444}) begin
      errors++; $display("FAIL rr_write_r4: got %h", {o_rf_we, o_rf_rdst, o_rf_data});
    end
    #1;
    checks++;
    if ({o_ll_ready, o_dbg_ready} !== 2'b01) begin
      errors++; $display("FAIL rr_dbg_ready: got %b want 01", {o_ll_ready, o_dbg_ready});
    end
    tick();
    checks++;
    if ({o_rf_we, o_rf_rdst, o_rf_data} !== {1'b1, 5'd5, 32'h55555555}) begin
      errors++; $display("FAIL rr_write_r5: got %h", {o_rf_we, o_rf_rdst, o_rf_data});
    end
    // Both contend twice more: LL then DBG.
    i_ll_valid = 1'b1;  i_ll_rdst = 5'd10;  i_ll_data = 32'hAAAA0010;
    i_dbg_valid = 1'b1; i_dbg_rdst = 5'd11; i_dbg_data = 32'hBBBB0011;
    #1;
    checks++;
    if ({o_ll_ready, o_dbg_ready} !== 2'b10) begin
      errors++; $display("FAIL rr_alt1_ready: got %b want 10", {o_ll_ready, o_dbg_ready});
    end
    tick();
    i_ll_rdst = 5'd12; i_ll_data = 32'hAAAA0012;
    #1;
    checks++;
    if ({o_ll_ready, o_dbg_ready} !== 2'b01) begin
      errors++; $display("FAIL rr_alt2_ready: got %b want 01", {o_ll_ready, o_dbg_ready});
    end
    tick();
    checks++;
    if ({o_rf_we, o_rf_rdst, o_rf_data} !== {1'b1, 5'd11, 32'hBBBB0011}) begin
      errors++; $display("FAIL rr_write_r11: got %h", {o_rf_we, o_rf_rdst, o_rf_data});
    end
    set_idle();
    tick();
  endtask

  task automatic test_starvation();
    do_reset();
    i_wb_we = 1'b1;    i_wb_rdst = 5'd1; i_wb_data = 32'h11111111;
    i_ll_valid = 1'b1; i_ll_rdst = 5'd6; i_ll_data = 32'h66666666;
    for (int unsigned k = 1; k <= LIMIT; k++) begin
      #1;
      checks++;
      if ({o_ll_ready, o_dbg_ready} !== 2'b00) begin
        errors++; $display("FAIL starve_denied_%0d: got %b want 00", k, {o_ll_ready, o_dbg_ready});
      end
      tick();
      checks++;
      if (o_stall_pipe !== (k == LIMIT)) begin
        errors++; $display("FAIL starve_stall_%0d: got %b want %b", k, o_stall_pipe, (k == LIMIT));
      end
    end
    #1;
    checks++;
    if ({o_ll_ready, o_dbg_ready} !== 2'b10) begin
      errors++; $display("FAIL starve_ll_granted: got %b want 10", {o_ll_ready, o_dbg_ready});
    end
    tick();
    i_ll_valid = 1'b0;
    checks++;
    if ({o_stall_pipe, o_rf_we, o_rf_rdst, o_rf_data} !== {1'b0, 1'b1, 5'd6, 32'h66666666}) begin
      errors++; $display("FAIL starve_ll_write: got %h", {o_stall_pipe, o_rf_we, o_rf_rdst, o_rf_data});
    end
    tick();
    checks++;
    if ({o_stall_pipe, o_rf_we, o_rf_rdst, o_rf_data} !== {1'b0, 1'b1, 5'd1, 32'h11111111}) begin
      errors++; $display("FAIL starve_wb_resume: got %h", {o_stall_pipe, o_rf_we, o_rf_rdst, o_rf_data});
    end
    set_idle();
    tick();
  endtask

  task automatic test_r0();
    do_reset();
    i_wb_we = 1'b1;     i_wb_rdst = 5'd0;  i_wb_data = 32'hDEADBEEF;
    i_dbg_valid = 1'b1; i_dbg_rdst = 5'd9; i_dbg_data = 32'h99999999;
    #1;
    checks++;
    if ({o_ll_ready, o_dbg_ready} !== 2'b01) begin
      errors++; $display("FAIL r0_dbg_ready: got %b want 01", {o_ll_ready, o_dbg_ready});
    end
    tick();
    i_dbg_valid = 1'b0;
    checks++;
    if ({o_rf_we, o_rf_rdst, o_rf_data} !== {1'b1, 5'd9, 32'h99999999}) begin
      errors++; $display("FAIL r0_dbg_write: got %h", {o_rf_we, o_rf_rdst, o_rf_data});
    end
    tick();
    checks++;
    if (o_rf_we !== 1'b0) begin
      errors++; $display("FAIL r0_wb_dropped: got we=%b want 0", o_rf_we);
    end
    i_wb_we = 1'b0;
    i_ll_valid = 1'b1; i_ll_rdst = 5'd0; i_ll_data = 32'h12345678;
    #1;
    checks++;
    if ({o_ll_ready, o_dbg_ready} !== 2'b10) begin
      errors++; $display("FAIL r0_ll_ready: got %b want 10", {o_ll_ready, o_dbg_ready});
    end
    tick();
    i_ll_valid = 1'b0;
    checks++;
    if ({o_rf_we, o_rf_rdst, o_rf_data} !== {1'b0, 5'd0, 32'h12345678}) begin
      errors++; $display("FAIL r0_ll_dropped: got %h", {o_rf_we, o_rf_rdst, o_rf_data});
    end
    set_idle();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_wb_we = 1'b1;    i_wb_rdst = 5'd2; i_wb_data = 32'h22222222;
    i_ll_valid = 1'b1; i_ll_rdst = 5'd8; i_ll_data = 32'h88888888;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({o_ll_ready, o_dbg_ready} !== 2'b00) begin
      errors++; $display("FAIL rstmid_ready_in_rst: got %b want 00", {o_ll_ready, o_dbg_ready});
    end
    tick();
    rst = 1'b0;
    i_wb_we = 1'b0;
    checks++;
    if ({o_stall_pipe, o_rf_we, o_rf_rdst, o_rf_data} !== 39'd0) begin
      errors++; $display("FAIL rstmid_rf_cleared: got %h want 0", {o_stall_pipe, o_rf_we, o_rf_rdst, o_rf_data});
    end
    #1;
    checks++;
    if ({o_ll_ready, o_dbg_ready} !== 2'b10) begin
      errors++; $display("FAIL rstmid_ll_after: got %b want 10", {o_ll_ready, o_dbg_ready});
    end
    tick();
    i_ll_valid = 1'b0;
    checks++;
    if ({o_rf_we, o_rf_rdst, o_rf_data} !== {1'b1, 5'd8, 32'h88888888}) begin
      errors++; $display("FAIL rstmid_ll_write: got %h", {o_rf_we, o_rf_rdst, o_rf_data});
    end
    set_idle();
    tick();
  endtask

  task automatic test_random();
    int g;
    bit ll_pend, dbg_pend;
    do_reset();
    rst = 1'b1;
    model_step(0);
    rst = 1'b0;
    ll_pend = 0;
    dbg_pend = 0;
    for (int unsigned n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      i_wb_we   = ($urandom_range(0, 9) < 8);
      i_wb_rdst = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      i_wb_data = $urandom;
      if (!ll_pend) begin
        i_ll_valid = $urandom_range(0, 1);
        i_ll_rdst  = 5'($urandom_range(0, 31));
        i_ll_data  = $urandom;
      end
      if (!dbg_pend) begin
        i_dbg_valid = ($urandom_range(0, 2) == 0);
        i_dbg_rdst  = 5'($urandom_range(0, 31));
        i_dbg_data  = $urandom;
      end
      #1;
      g = model_pick();
      checks++;
      if ({o_ll_ready, o_dbg_ready} !== {(g == 2), (g == 3)}) begin
        errors++; $display("FAIL rand_ready@%0d: got %b want %b", n, {o_ll_ready, o_dbg_ready}, {(g == 2), (g == 3)});
      end
      checks++;
      if ({o_stall_pipe, o_rf_we} !== {m_stall, m_we}) begin
        errors++; $display("FAIL rand_stall_we@%0d: got %b want %b", n, {o_stall_pipe, o_rf_we}, {m_stall, m_we});
      end
      if (m_we) begin
        checks++;
        if ({o_rf_rdst, o_rf_data} !== {m_rdst, m_data}) begin
          errors++; $display("FAIL rand_rf@%0d: got %h want %h", n, {o_rf_rdst, o_rf_data}, {m_rdst, m_data});
        end
      end
      model_step(g);
      ll_pend  = i_ll_valid && (g != 2);
      dbg_pend = i_dbg_valid && (g != 3);
      tick();
    end
    rst = 1'b0;
    set_idle();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_single_ll();
    test_wb_rr();
    test_starvation();
    test_r0();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
